// File: rtl/alif_param_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alif_param_load_sequencer_if
// Description : Request / loader-side signal bundle for the ALIF parameter
//               load sequencer. The master modport is the side that issues
//               requests and steps the loader enable. The slave modport is
//               the sequencer itself.
// Signals     : enable          - step enable, shared with the loader
//               req_valid[1:0]  - per-port request, held until acknowledged
//               req0_params     - port 0 parameter set (31 bits)
//               req1_params     - port 1 parameter set (31 bits)
//               abort           - terminate the frame in flight
//               req_ack[1:0]    - one-cycle accept pulse per port
//               load_enable_out - loader load_enable
//               serial_data_out - loader serial_data_in
//               busy            - frame in progress
//               done            - one-cycle pulse, full frame delivered
//               aborted         - one-cycle pulse, frame cut short
//               last_grant      - port granted most recently
// Revision    : 1.0 - initial release
// ============================================================================
interface alif_param_load_sequencer_if;
    logic        enable;
    logic [1:0]  req_valid;
    logic [30:0] req0_params;
    logic [30:0] req1_params;
    logic        abort;
    logic [1:0]  req_ack;
    logic        load_enable_out;
    logic        serial_data_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        last_grant;

    modport master (
        output enable, req_valid, req0_params, req1_params, abort,
        input  req_ack, load_enable_out, serial_data_out, busy, done,
               aborted, last_grant
    );

    modport slave (
        input  enable, req_valid, req0_params, req1_params, abort,
        output req_ack, load_enable_out, serial_data_out, busy, done,
               aborted, last_grant
    );
endinterface
`default_nettype wire

// File: rtl/alif_param_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alif_param_load_sequencer
// Description : Two-port round-robin scheduler and serializer feeding the
//               ALIF neuron serial parameter loader. A granted parameter set
//               is sent as one preamble cycle, 5 x 8 bits MSB-first, then one
//               release cycle. The loader shares the same enable net, so the
//               two blocks step in lockstep.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               bus   - alif_param_load_sequencer_if.slave (requests in,
//                       loader drive and status out)
// Parameter packing (req*_params, 31 bits, fields right-aligned):
//               [30:26] unused, [25:23] wa, [22:20] wb, [19:12] leak_rate,
//               [11:4] thr_min, [3:0] leak_cycles
// Revision    : 1.0 - initial release
// ============================================================================
module alif_param_load_sequencer #(
    parameter int FIELD_BITS = 8,
    parameter int NUM_FIELDS = 5
) (
    input  wire logic clk,
    input  wire logic reset,
    alif_param_load_sequencer_if.slave bus
);

    localparam int FRAME_BITS = FIELD_BITS * NUM_FIELDS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        SHIFT    = 2'd2,
        TAIL     = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [FRAME_BITS-1:0]  frame, frame_next;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_next;
    logic [1:0]             ack_q, ack_next;
    logic                   done_q, done_next;
    logic                   aborted_q, aborted_next;
    logic                   grant_q, grant_next;
    logic                   winner;

    // Widen each field to a full byte slot, zero padded on the MSB side.
    function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [30:0] p);
        return {{(FIELD_BITS-3){1'b0}}, p[25:23],
                {(FIELD_BITS-3){1'b0}}, p[22:20],
                p[19:12],
                p[11:4],
                {(FIELD_BITS-4){1'b0}}, p[3:0]};
    endfunction

    // Upper parameter bits carry no field.
    logic unused_pad;
    assign unused_pad = ^{bus.req0_params[30:26], bus.req1_params[30:26]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            frame     <= '0;
            bit_cnt   <= '0;
            ack_q     <= 2'b00;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            grant_q   <= 1'b1;   // port 0 wins the first contention
        end else begin
            state     <= state_next;
            frame     <= frame_next;
            bit_cnt   <= bit_cnt_next;
            ack_q     <= ack_next;
            done_q    <= done_next;
            aborted_q <= aborted_next;
            grant_q   <= grant_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Pulse outputs default to 0 so they last exactly
    // one cycle even while enable is low.
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state;
        frame_next   = frame;
        bit_cnt_next = bit_cnt;
        ack_next     = 2'b00;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        grant_next   = grant_q;
        winner       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.enable && (bus.req_valid != 2'b00)) begin
                    // Contention goes to the port not served last time.
                    if (bus.req_valid == 2'b11) begin
                        winner = ~grant_q;
                    end else begin
                        winner = bus.req_valid[1];
                    end
                    grant_next = winner;
                    ack_next   = winner ? 2'b10 : 2'b01;
                    frame_next = winner ? pack_frame(bus.req1_params)
                                        : pack_frame(bus.req0_params);
                    state_next = PREAMBLE;
                end
            end

            PREAMBLE: begin
                // Abort is honoured even on an enable-low edge.
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = IDLE;
                end else if (bus.enable) begin
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end

            SHIFT: begin
                if (bus.abort) begin
                    aborted_next = 1'b1;
                    state_next   = IDLE;
                end else if (bus.enable) begin
                    frame_next   = {frame[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_next = bit_cnt + CNT_ONE;
                    if (bit_cnt == LAST_BIT) begin
                        state_next = TAIL;
                    end
                end
            end

            TAIL: begin
                // Load enable is low here so the loader can leave READY.
                if (bus.enable) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, all decoded from registered state.
    // ------------------------------------------------------------------
    assign bus.req_ack         = ack_q;
    assign bus.done            = done_q;
    assign bus.aborted         = aborted_q;
    assign bus.last_grant      = grant_q;
    assign bus.busy            = (state != IDLE);
    assign bus.load_enable_out = (state == PREAMBLE) || (state == SHIFT);
    assign bus.serial_data_out = (state == SHIFT) && frame[FRAME_BITS-1];

endmodule
`default_nettype wire
